// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between UART receiver and consumer: first-word fall-through, fill level, sticky overflow.
// Optional saturating drop counter enabled by defining UART_RX_FIFO_DROP_CNT_EN.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic                  clr_ovf,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]            drop_cnt
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    // A pop in the same cycle frees a slot, so a write into a full FIFO is still accepted.
    always_comb begin
        pop_ok  = rd_en && !empty;
        push_ok = wr_en && (!full || pop_ok);
        drop    = wr_en && full && !pop_ok;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed test-plan steps plus random traffic against a queue-based model.
// Drop-counter checks are active when UART_RX_FIFO_DROP_CNT_EN is defined.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    int         m_drop = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
`ifdef UART_RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(q.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(q.size() == 16));
        chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
        chk({tag, "_data"},  32'(rd_data), (q.size() > 0) ? 32'(q[0]) : 32'h0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk({tag, "_dcnt"},  32'(drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock cycle with the given inputs; model advances, then outputs are compared.
    task automatic cyc(input string tag, input logic w, input logic [7:0] d,
                       input logic r, input logic c);
        logic pop, push, drp;
        logic [7:0] dummy;
        wr_en = w; wr_data = d; rd_en = r; clr_ovf = c;
        pop  = r && (q.size() > 0);
        push = w && ((q.size() < 16) || pop);
        drp  = w && !push;
        if (pop)  dummy = q.pop_front();
        if (push) q.push_back(d);
        if (drp)      m_ovf = 1'b1;
        else if (c)   m_ovf = 1'b0;
        if (c)        m_drop = drp ? 1 : 0;
        else if (drp) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input logic w);
        rst = 1'b1; wr_en = w; wr_data = 8'hEE;
        q.delete(); m_ovf = 1'b0; m_drop = 0;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset("rst0", 1'b0);

        // 1: single byte in and out
        cyc("t1_wr", 1, 8'h41, 0, 0);
        chk("t1_data_const", 32'(rd_data), 32'h41);
        chk("t1_cnt_const", 32'(count), 32'd1);
        cyc("t1_rd", 0, 8'h00, 1, 0);
        chk("t1_empty_const", 32'(empty), 32'd1);
        chk("t1_zero_const", 32'(rd_data), 32'h0);

        // 2: fill, drop, drain in order
        for (int i = 0; i < 16; i++) cyc("t2_fill", 1, 8'(i), 0, 0);
        chk("t2_full_const", 32'(full), 32'd1);
        cyc("t2_drop", 1, 8'hAA, 0, 0);
        chk("t2_ovf_const", 32'(overflow), 32'd1);
        chk("t2_cnt16_const", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", 32'(rd_data), 32'(i));
            cyc("t2_drain", 0, 8'h00, 1, 0);
        end
        cyc("t2_clr", 0, 8'h00, 0, 1);

        // 3: push+pop while full
        for (int i = 0; i < 16; i++) cyc("t3_fill", 1, 8'(8'h80 + i), 0, 0);
        cyc("t3_pp", 1, 8'h55, 1, 0);
        chk("t3_cnt_const", 32'(count), 32'd16);
        chk("t3_ovf_const", 32'(overflow), 32'd0);
        for (int i = 0; i < 15; i++) cyc("t3_drain", 0, 8'h00, 1, 0);
        chk("t3_last_const", 32'(rd_data), 32'h55);
        cyc("t3_drain_last", 0, 8'h00, 1, 0);

        // 4: push+pop while empty, then underflow attempts
        cyc("t4_pp", 1, 8'h33, 1, 0);
        chk("t4_data_const", 32'(rd_data), 32'h33);
        cyc("t4_rd", 0, 8'h00, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t4_under", 0, 8'h00, 1, 0);
        chk("t4_cnt_const", 32'(count), 32'd0);

        // 5: pointer wrap, then reset with entries stored (wr_en coincident with rst)
        for (int i = 0; i < 40; i++) begin
            cyc("t5_wr", 1, 8'(i), 0, 0);
            chk("t5_val", 32'(rd_data), 32'(i));
            cyc("t5_rd", 0, 8'h00, 1, 0);
        end
        for (int i = 0; i < 5; i++) cyc("t5_load", 1, 8'(8'hC0 + i), 0, 0);
        do_reset("t5_rst", 1'b1);
        chk("t5_rst_cnt_const", 32'(count), 32'd0);

        // 6: long overflow run, then clear
        for (int i = 0; i < 16; i++) cyc("t6_fill", 1, 8'(i), 0, 0);
        for (int i = 0; i < 300; i++) cyc("t6_drop", 1, 8'hFF, 0, 0);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("t6_dcnt_const", 32'(drop_cnt), 32'd255);
`endif
        chk("t6_ovf_const", 32'(overflow), 32'd1);
        cyc("t6_clr_and_drop", 1, 8'hFF, 0, 1);
        chk("t6_setwins_const", 32'(overflow), 32'd1);
        cyc("t6_clr", 0, 8'h00, 0, 1);
        chk("t6_clr_const", 32'(overflow), 32'd0);

        // Random traffic, write-heavy and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 300) % 2 == 0) ? 70 : 30;
            cyc("rnd", ($urandom_range(99) < wp), 8'($urandom),
                ($urandom_range(99) < 50), ($urandom_range(99) < 3));
            if ($urandom_range(999) == 0) do_reset("rnd_rst", 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver and upstream of the display/consumer logic. It captures each byte strobed out by the receiver and stores it in a circular FIFO. The consumer drains the FIFO at its own pace, for example one byte per debounced button press, so bytes are not lost while earlier ones are being shown. It also reports fill level and a sticky overflow condition.

Parameters:
DATA_W, 8, width of each stored byte
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries)

Ports:
clk  input  1  system clock (100 MHz board clock)
rst  input  1  synchronous active-high reset
wr_en  input  1  write strobe; connect to receiver rx_rdy (one-cycle pulse per byte)
wr_data  input  DATA_W  byte to store; connect to receiver rx_data, valid when wr_en=1
rd_en  input  1  pop request; single-cycle pulse from consumer (debounced, edge-detected)
clr_ovf  input  1  clears overflow flag
rd_data  output  DATA_W  head-of-FIFO byte (first-word fall-through)
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds DEPTH entries
count  output  DEPTH_LOG2+1  current number of stored entries, 0..DEPTH
overflow  output  1  sticky: a write was dropped because the FIFO was full

Behaviour:
- All state updates on rising edge of clk; reset is synchronous, active-high, and has priority over everything else.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_data=0. Storage array is not reset.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH (15 -> 0). count is maintained separately; full = (count==DEPTH), empty = (count==0), both registered/derived from registered count.
- Push: wr_en=1 and (not full, or pop accepted in the same cycle) -> mem[wr_ptr] <= wr_data, wr_ptr increments.
- Pop: rd_en=1 and not empty -> rd_ptr increments. rd_en while empty is ignored with no pointer change.
- Count update: push only +1; pop only -1; push+pop both accepted -> unchanged.
- Simultaneous push+pop when full: both accepted, count stays DEPTH, overflow not set.
- Simultaneous push+pop when empty: pop ignored, push accepted, count 0 -> 1.
- Drop: wr_en=1 while full and no accepted pop -> byte discarded, pointers and count unchanged, overflow <= 1.
- overflow clears only on rst or clr_ovf=1. If clr_ovf and a drop occur in the same cycle, the set wins and overflow = 1.
- rd_data is first-word fall-through: equals mem[rd_ptr] whenever empty=0, and equals 0 when empty=1.
- Latency: a byte written in cycle N is visible on rd_data, with empty=0, from cycle N+1.
- After a pop in cycle N, the next entry is on rd_data in cycle N+1.
- rd_en held high pops one entry per cycle until empty; the consumer is responsible for pulse-shaping its input.
- Reset mid-operation: all contents are logically discarded (count=0). A wr_en coincident with rst is ignored.

Optional Feature:
Macro UART_RX_FIFO_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0], reset 0.
- drop_cnt increments by 1 on every dropped write and saturates at 255.
- drop_cnt is cleared by rst or clr_ovf. If a clear and a drop happen in the same cycle, drop_cnt becomes 1.
- Not defined: no drop_cnt port and no counter logic; only the sticky overflow flag reports drops.

Test Plan:
1. Reset, then write 0x41 -> next cycle: empty=0, count=1, rd_data=0x41. Pop -> next cycle: empty=1, count=0, rd_data=0x00.
2. Write 0x00..0x0F (16 bytes) -> full=1, count=16. 17th write 0xAA -> dropped, overflow=1, count=16. Pop all 16 -> values 0x00..0x0F in order, 0xAA never appears.
3. Fill to full, then push 0x55 and pop in the same cycle -> count stays 16, overflow=0. After draining, the last byte read is 0x55.
4. From empty, push 0x33 and rd_en in the same cycle -> count=1, rd_data=0x33. rd_en pulses while empty -> count stays 0, no underflow or wrap.
5. Pointer wrap: do 40 write/pop pairs with values 0..39 -> every value is read back in order across the 15->0 wraps. Assert reset with 5 entries stored -> count=0, empty=1, rd_data=0.
6. With UART_RX_FIFO_DROP_CNT_EN: fill, then attempt 300 extra writes -> drop_cnt=255 and overflow=1. clr_ovf -> drop_cnt=0 and overflow=0 next cycle.
